spi_frame_master: RTL and testbench



---
 rtl/spi_frame_pkg.sv | 28 ++
 rtl/spi_sclk_gen.sv | 43 ++++
 rtl/spi_frame_master.sv | 160 ++++++++++++++++
 tb/tb_spi_frame_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and elaboration helpers for the SPI frame master.
// Holds the FSM state encoding, a width helper and the legal-parameter check.
package spi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(
        input int frame_bits,
        input int clk_div,
        input int channels,
        input int gap_clks
    );
        return (frame_bits >= 2) && (frame_bits <= 1024) &&
               (clk_div >= 2) && ((clk_div % 2) == 0) &&
               (channels >= 1) && (channels <= 8) &&
               (gap_clks >= 1);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Bit-slot divider: registered sclk (low first half, high second half of each slot).
// o_rise marks the cycle before sclk rises, o_slot_end the last cycle of a slot; idle while i_run is low.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_sclk,
    output logic o_rise,
    output logic o_slot_end
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int HALF  = CLK_DIV / 2;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_sclk;

    always_comb begin
        w_div_next = '0;
        if (i_run && (r_div != DIV_W'(CLK_DIV - 1))) begin
            w_div_next = r_div + 1'b1;
        end
    end

    // sclk is precomputed from the next divider value so it is a clean flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_div  <= w_div_next;
            r_sclk <= i_run && (w_div_next >= DIV_W'(HALF));
        end
    end

    assign o_sclk     = r_sclk;
    assign o_rise     = i_run && (r_div == DIV_W'(HALF - 1));
    assign o_slot_end = i_run && (r_div == DIV_W'(CLK_DIV - 1));

endmodule

// File: rtl/spi_frame_master.sv
// Flow-controlled SPI transmit master: one word per handshake, framed by a per-channel active-low select.
// First bit one cycle after accept; s_ready low from accept until the post-frame gap ends.
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 4,
    parameter int CHANNELS   = 2,
    parameter int GAP_CLKS   = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [FRAME_BITS-1:0]               s_data,
    input  logic [clog2_min1(CHANNELS)-1:0]     s_chan,
    output logic                                sclk,
    output logic                                mosi,
    output logic [CHANNELS-1:0]                 sync_n,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                chan_err
);

    localparam int BIT_W = $clog2(FRAME_BITS) + 1;
    localparam int GAP_W = $clog2(GAP_CLKS) + 1;

    if (!params_ok(FRAME_BITS, CLK_DIV, CHANNELS, GAP_CLKS)) begin : g_param_check
        $error("spi_frame_master: illegal parameter combination");
    end

    state_t                r_state;
    state_t                w_state_next;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_shift_next;
    logic [BIT_W-1:0]      r_bit;
    logic [GAP_W-1:0]      r_gap;
    logic                  r_mosi;
    logic [CHANNELS-1:0]   r_sync_n;
    logic [CHANNELS-1:0]   w_cs_dec;
    logic                  r_s_ready;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_chan_err;
    logic                  w_accept;
    logic                  w_chan_bad;
    logic                  w_load;
    logic                  w_last;
    logic                  w_gap_last;
    logic                  w_run;
    logic                  w_sclk;
    logic                  w_rise;
    logic                  w_slot_end;

    assign w_run = (r_state == SHIFT);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .i_run      (w_run),
        .o_sclk     (w_sclk),
        .o_rise     (w_rise),
        .o_slot_end (w_slot_end)
    );

    // Next-state and datapath steering.
    always_comb begin
        w_state_next = r_state;
        w_accept     = (r_state == IDLE) && r_s_ready && s_valid;
        w_chan_bad   = (int'(s_chan) >= CHANNELS);
        w_load       = w_accept && !w_chan_bad;
        // r_bit counts sclk rises, so at the final slot_end it already equals FRAME_BITS.
        w_last       = w_run && w_slot_end && (r_bit == BIT_W'(FRAME_BITS));
        w_gap_last   = (r_state == GAP) && (r_gap == GAP_W'(GAP_CLKS - 1));
        w_shift_next = '0;
        w_cs_dec     = '1;

        if (MSB_FIRST) begin
            w_shift_next = {r_shift[FRAME_BITS-2:0], 1'b0};
        end else begin
            w_shift_next = {1'b0, r_shift[FRAME_BITS-1:1]};
        end

        for (int i = 0; i < CHANNELS; i++) begin
            w_cs_dec[i] = (int'(s_chan) != i);
        end

        case (r_state)
            IDLE:    if (w_load)     w_state_next = SHIFT;
            SHIFT:   if (w_last)     w_state_next = GAP;
            GAP:     if (w_gap_last) w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_bit        <= '0;
            r_gap        <= '0;
            r_mosi       <= 1'b0;
            r_sync_n     <= '1;
            r_s_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_chan_err   <= 1'b0;
        end else begin
            // s_ready follows en with one cycle of delay so the port stays a flop output.
            r_s_ready    <= (w_state_next == IDLE) && en;
            r_busy       <= (w_state_next != IDLE);
            r_frame_done <= w_last;
            r_chan_err   <= w_accept && w_chan_bad;

            if (w_load) begin
                r_shift  <= s_data;
                r_mosi   <= MSB_FIRST ? s_data[FRAME_BITS-1] : s_data[0];
                r_sync_n <= w_cs_dec;
                r_bit    <= '0;
            end else if (w_run) begin
                if (w_rise) begin
                    r_bit <= r_bit + 1'b1;
                end
                if (w_last) begin
                    r_mosi   <= 1'b0;
                    r_sync_n <= '1;
                end else if (w_slot_end) begin
                    r_shift <= w_shift_next;
                    r_mosi  <= MSB_FIRST ? w_shift_next[FRAME_BITS-1] : w_shift_next[0];
                end
            end

            if (w_last) begin
                r_gap <= '0;
            end else if (r_state == GAP) begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign sclk       = w_sclk;
    assign mosi       = r_mosi;
    assign sync_n     = r_sync_n;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign chan_err   = r_chan_err;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: MSB/LSB-first instances share stimulus, a 3-channel
// instance exercises the out-of-range channel path.
module tb_spi_frame_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'h0;
    logic        s_chan = 1'b0;

    logic        s_ready, sclk, mosi, busy, frame_done, chan_err;
    logic [1:0]  sync_n;
    logic        s_ready_l, sclk_l, mosi_l, busy_l, frame_done_l, chan_err_l;
    logic [1:0]  sync_n_l;

    logic        en3 = 1'b0;
    logic        s_valid3 = 1'b0;
    logic [15:0] s_data3 = 16'h0;
    logic [1:0]  s_chan3 = 2'd0;
    logic        s_ready3, sclk3, mosi3, busy3, frame_done3, chan_err3;
    logic [2:0]  sync_n3;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_frame_master u_msb (
        .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_chan(s_chan), .sclk(sclk), .mosi(mosi), .sync_n(sync_n),
        .busy(busy), .frame_done(frame_done), .chan_err(chan_err)
    );

    spi_frame_master #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready_l),
        .s_data(s_data), .s_chan(s_chan), .sclk(sclk_l), .mosi(mosi_l), .sync_n(sync_n_l),
        .busy(busy_l), .frame_done(frame_done_l), .chan_err(chan_err_l)
    );

    spi_frame_master #(.CHANNELS(3)) u_ch3 (
        .clk(clk), .rst(rst), .en(en3), .s_valid(s_valid3), .s_ready(s_ready3),
        .s_data(s_data3), .s_chan(s_chan3), .sclk(sclk3), .mosi(mosi3), .sync_n(sync_n3),
        .busy(busy3), .frame_done(frame_done3), .chan_err(chan_err3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends one word through the shared MSB/LSB pair and checks the whole frame timeline.
    task automatic run_frame(input string tag, input logic [15:0] data, input logic ch,
                             input logic [1:0] exp_sync, input logic [15:0] exp_m,
                             input logic [15:0] exp_l, input int drop_en_j, input int exp_rdy_j);
        int first_cs, last_cs, cs_ok, rises_m, first_rise, done_cnt, done_j, done_l, rdy_j, busy_cnt, w;
        logic [15:0] bits_m, bits_l;
        logic prev_m, prev_l;
        first_cs = -1; last_cs = -1; cs_ok = 0; rises_m = 0; first_rise = -1;
        done_cnt = 0; done_j = -1; done_l = 0; rdy_j = -1; busy_cnt = 0;
        bits_m = '0; bits_l = '0; prev_m = 1'b0; prev_l = 1'b0;
        @(negedge clk);
        w = 0;
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready_before"}, s_ready, 1);
        s_data = data; s_chan = ch; s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_data = ~data; s_chan = ~ch;
        for (int j = 1; j <= 75; j++) begin
            @(negedge clk);
            if (sync_n != 2'b11) begin
                if (first_cs < 0) first_cs = j;
                last_cs = j;
                if (sync_n == exp_sync) cs_ok++;
            end
            if (sclk && !prev_m) begin
                rises_m++;
                bits_m = {bits_m[14:0], mosi};
                if (first_rise < 0) first_rise = j;
            end
            if (sclk_l && !prev_l) bits_l = {bits_l[14:0], mosi_l};
            prev_m = sclk;
            prev_l = sclk_l;
            if (frame_done) begin done_cnt++; done_j = j; end
            if (frame_done_l) done_l++;
            if (s_ready && rdy_j < 0) rdy_j = j;
            if (busy) busy_cnt++;
            if (j == drop_en_j) en = 1'b0;
        end
        chk({tag, "_cs_first"}, first_cs, 1);
        chk({tag, "_cs_last"}, last_cs, 64);
        chk({tag, "_cs_value_cycles"}, cs_ok, 64);
        chk({tag, "_sclk_rises"}, rises_m, 16);
        chk({tag, "_first_rise"}, first_rise, 3);
        chk({tag, "_msb_bits"}, bits_m, exp_m);
        chk({tag, "_lsb_bits"}, bits_l, exp_l);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_cycle"}, done_j, 65);
        chk({tag, "_done_lsb"}, done_l, 1);
        chk({tag, "_ready_cycle"}, rdy_j, exp_rdy_j);
        chk({tag, "_busy_cycles"}, busy_cnt, 66);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc[3];
        int k, lim, cnt_err, err_j, cs3, sclk3_hi, rdy3_lo, busy3_hi, done_after;
        logic [1:0] exp_s;

        // Reset state, with en already high to show reset dominates.
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_sync_n", sync_n, 2'b11);
        chk("rst_outputs_l", {s_ready_l, sclk_l, mosi_l, sync_n_l, busy_l, frame_done_l, chan_err_l}, 8'b0001_1000);
        chk("rst_outputs_ch3", {s_ready3, sclk3, mosi3, sync_n3, busy3, frame_done3, chan_err3}, 9'b000_111_000);
        en = 1'b1; en3 = 1'b1;
        @(negedge clk);
        chk("rst_ready_held", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {frame_done, chan_err}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_before_first_edge", s_ready, 0);
        @(negedge clk);
        chk("ready_after_rst", s_ready, 1);

        // Basic frame, both bit orders.
        run_frame("a5c3", 16'hA5C3, 1'b1, 2'b01, 16'hA5C3, 16'hC3A5, 0, 67);

        // Back-to-back words under continuous s_valid.
        @(negedge clk);
        s_data = 16'h1111; s_chan = 1'b1; s_valid = 1'b1;
        k = 0;
        lim = cyc + 400;
        while (k < 3 && cyc < lim) begin
            @(negedge clk);
            if (s_ready) begin
                acc[k] = cyc;
                exp_s = (k == 1) ? 2'b10 : 2'b01;
                @(posedge clk);
                #1;
                k++;
                if (k == 1) begin s_data = 16'h2222; s_chan = 1'b0; end
                else if (k == 2) begin s_data = 16'h3333; s_chan = 1'b1; end
                else s_valid = 1'b0;
                @(negedge clk);
                chk("queue_cs", sync_n, exp_s);
            end
        end
        s_valid = 1'b0;
        chk("queue_accepts", k, 3);
        chk("queue_period_01", acc[1] - acc[0], 67);
        chk("queue_period_12", acc[2] - acc[1], 67);

        // Out-of-range channel on the 3-channel instance.
        @(negedge clk);
        chk("ce_ready_before", s_ready3, 1);
        s_data3 = 16'hFFFF; s_chan3 = 2'd3; s_valid3 = 1'b1;
        @(posedge clk);
        #1 s_valid3 = 1'b0;
        cnt_err = 0; err_j = -1; cs3 = 0; sclk3_hi = 0; rdy3_lo = 0; busy3_hi = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (chan_err3) begin cnt_err++; err_j = j; end
            if (sync_n3 != 3'b111) cs3++;
            if (sclk3) sclk3_hi++;
            if (!s_ready3) rdy3_lo++;
            if (busy3) busy3_hi++;
        end
        chk("ce_pulses", cnt_err, 1);
        chk("ce_pulse_cycle", err_j, 1);
        chk("ce_cs_low_cycles", cs3, 0);
        chk("ce_sclk_high_cycles", sclk3_hi, 0);
        chk("ce_ready_low_cycles", rdy3_lo, 0);
        chk("ce_busy_cycles", busy3_hi, 0);
        s_chan3 = 2'd2; s_valid3 = 1'b1;
        @(posedge clk);
        #1 s_valid3 = 1'b0;
        @(negedge clk);
        chk("ch2_cs", sync_n3, 3'b011);
        chk("ch2_no_err", chan_err3, 0);

        // Reset in the middle of slot 5.
        @(negedge clk);
        w_ready();
        s_data = 16'hFFFF; s_chan = 1'b1; s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        for (int j = 1; j <= 21; j++) @(negedge clk);
        chk("pre_rst_cs", sync_n, 2'b01);
        chk("pre_rst_mosi", mosi, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_mosi", mosi, 0);
        chk("mid_rst_sync_n", sync_n, 2'b11);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", s_ready, 0);
        done_after = 0;
        for (int j = 0; j < 70; j++) begin
            @(negedge clk);
            if (frame_done) done_after++;
        end
        chk("mid_rst_no_done", done_after, 0);
        run_frame("post_rst", 16'h1234, 1'b0, 2'b10, 16'h1234, 16'h2C48, 0, 67);

        // en dropped during slot 3.
        run_frame("en_drop", 16'h00FF, 1'b1, 2'b01, 16'h00FF, 16'hFF00, 13, -1);
        k = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (s_ready) k++;
        end
        chk("en_low_ready_cycles", k, 0);
        en = 1'b1;
        @(negedge clk);
        chk("en_back_ready", s_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    task automatic w_ready();
        int w;
        w = 0;
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("wait_ready", s_ready, 1);
    endtask

endmodule
